// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: datapath widths, the canonical NOP encoding,
// and the IF/ID register payload that decode and the hazard unit also use.
package if_stage_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus: the fetch stage presents a byte address and the
// memory answers combinationally with the instruction in the same cycle.
interface if_stage_if #(
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0] addr;
  logic [31:0]       instr;

  modport master (output addr, input instr);
  modport slave  (input addr, output instr);

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with write-enable (stall) and flush (bubble insert).
// Flush replaces the instruction with a NOP and clears valid but keeps the
// PC fields, so the bubble still carries a plausible address for debug.
module if_stage_if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // Register update: reset > flush > enabled capture > hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      q.instr    <= NOP_INSTR;
      q.pc       <= '0;
      q.pc_plus4 <= '0;
      q.valid    <= 1'b0;
    end else if (flush) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address,
// and captures {instr, pc, pc+4} into IF/ID. Redirect beats stall beats
// sequential fetch; the instruction fetched during a redirect cycle is dropped.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0]    RESET_PC    = 32'h0000_0000,
  parameter int                 IMEM_ADDR_W = 10,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = if_stage_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_target,
  if_stage_if.master         imem,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [XLEN-1:0]    ifid_pc,
  output logic [XLEN-1:0]    ifid_pc_plus4,
  output logic               ifid_valid,
  output logic [XLEN-1:0]    pc,
  output logic               misaligned_target
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_next;
  if_id_t          ifid_d;
  if_id_t          ifid_q;

  assign pc_plus4 = pc + 32'd4;

  // Fetch wraps within the instruction memory; the PC itself does not.
  assign imem.addr = pc[IMEM_ADDR_W-1:0];

  // Next-PC select: redirect (word-aligned target) > stall (hold) > pc+4.
  always_comb begin
    // NOTE: defaulting first guarantees every path assigns pc_next, so no
    // latch is inferred.
    pc_next = pc;
    if (redirect) begin
      pc_next = {redirect_target[XLEN-1:2], 2'b00};
    end else if (!stall) begin
      pc_next = pc_plus4;
    end
  end

  // PC register and one-cycle misaligned-target pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc                <= {RESET_PC[XLEN-1:2], 2'b00};
      misaligned_target <= 1'b0;
    end else begin
      pc                <= pc_next;
      misaligned_target <= redirect & (redirect_target[1:0] != 2'b00);
    end
  end

  assign ifid_d = '{instr: imem.instr, pc: pc, pc_plus4: pc_plus4, valid: 1'b1};

  if_stage_if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk  (clk),
    .reset(reset),
    .en   (!stall),
    .flush(redirect),
    .d    (ifid_d),
    .q    (ifid_q)
  );

  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_valid    = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, free-run fetch, stall, redirect,
// redirect-over-stall, misaligned target, address wrap and reset mid-stall.
// The instruction memory returns 32'hA000_0000 | byte_address.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] pc;
  logic        misaligned_target;

  int checks = 0;
  int passes = 0;

  if_stage_if #(.ADDR_W(10)) imem_bus ();

  assign imem_bus.instr = 32'hA000_0000 | {22'd0, imem_bus.addr};

  if_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_ADDR_W(10),
    .NOP_INSTR  (32'h0000_0013)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .imem             (imem_bus.master),
    .ifid_instr       (ifid_instr),
    .ifid_pc          (ifid_pc),
    .ifid_pc_plus4    (ifid_pc_plus4),
    .ifid_valid       (ifid_valid),
    .pc               (pc),
    .misaligned_target(misaligned_target)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    step(); step();
    checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else passes++;
    checks++; if (ifid_instr !== 32'h13) $display("FAIL reset_instr: got %h want %h", ifid_instr, 32'h13); else passes++;
    checks++; if (ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h0) $display("FAIL reset_ifid_pc: got %h/%h want 0/0", ifid_pc, ifid_pc_plus4); else passes++;
    checks++; if (ifid_valid !== 1'b0 || misaligned_target !== 1'b0) $display("FAIL reset_flags: valid=%b mis=%b want 0/0", ifid_valid, misaligned_target); else passes++;
    reset = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || imem_bus.addr !== 10'h0) $display("FAIL first_bubble: valid=%b addr=%h want 0/000", ifid_valid, imem_bus.addr); else passes++;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'(i) * 32'd4;
      step();
      checks++;
      if (ifid_pc !== exp_pc || ifid_instr !== (32'hA000_0000 | exp_pc) ||
          ifid_pc_plus4 !== exp_pc + 32'd4 || ifid_valid !== 1'b1 || pc !== exp_pc + 32'd4)
        $display("FAIL free_run[%0d]: ifid_pc=%h instr=%h pc4=%h valid=%b pc=%h want ifid_pc=%h",
                 i, ifid_pc, ifid_instr, ifid_pc_plus4, ifid_valid, pc, exp_pc);
      else passes++;
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== 32'h10 || ifid_pc !== 32'h0C || imem_bus.addr !== 10'h10 || ifid_instr !== 32'hA000_000C)
        $display("FAIL stall[%0d]: pc=%h ifid_pc=%h addr=%h instr=%h want 10/0c/010/a000000c",
                 i, pc, ifid_pc, imem_bus.addr, ifid_instr);
      else passes++;
    end
    stall = 1'b0;
    step();
    checks++; if (ifid_pc !== 32'h10 || ifid_instr !== 32'hA000_0010 || pc !== 32'h14)
      $display("FAIL stall_release: ifid_pc=%h instr=%h pc=%h want 10/a0000010/14", ifid_pc, ifid_instr, pc); else passes++;
    step();
    checks++; if (pc !== 32'h18 || ifid_pc !== 32'h14) $display("FAIL pre_redirect: pc=%h ifid_pc=%h want 18/14", pc, ifid_pc); else passes++;
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_target = 32'h40;
    step();
    checks++; if (pc !== 32'h40 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13 || ifid_pc !== 32'h14 || misaligned_target !== 1'b0)
      $display("FAIL redirect_flush: pc=%h valid=%b instr=%h ifid_pc=%h mis=%b want 40/0/13/14/0",
               pc, ifid_valid, ifid_instr, ifid_pc, misaligned_target); else passes++;
    redirect = 1'b0;
    step();
    checks++; if (ifid_pc !== 32'h40 || ifid_valid !== 1'b1 || ifid_instr !== 32'hA000_0040 || pc !== 32'h44)
      $display("FAIL redirect_fetch: ifid_pc=%h valid=%b instr=%h pc=%h want 40/1/a0000040/44",
               ifid_pc, ifid_valid, ifid_instr, pc); else passes++;
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; stall = 1'b1; redirect_target = 32'h80;
    step();
    checks++; if (pc !== 32'h80 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13)
      $display("FAIL redirect_over_stall: pc=%h valid=%b instr=%h want 80/0/13", pc, ifid_valid, ifid_instr); else passes++;
    stall = 1'b0; redirect_target = 32'h90;
    step();
    checks++; if (pc !== 32'h90 || ifid_valid !== 1'b0 || ifid_pc !== 32'h40)
      $display("FAIL redirect_b2b: pc=%h valid=%b ifid_pc=%h want 90/0/40", pc, ifid_valid, ifid_pc); else passes++;
    redirect = 1'b0;
    step();
    checks++; if (ifid_pc !== 32'h90 || ifid_valid !== 1'b1 || pc !== 32'h94)
      $display("FAIL redirect_b2b_fetch: ifid_pc=%h valid=%b pc=%h want 90/1/94", ifid_pc, ifid_valid, pc); else passes++;
  endtask

  task automatic test_misaligned();
    redirect = 1'b1; redirect_target = 32'h46;
    step();
    checks++; if (pc !== 32'h44 || misaligned_target !== 1'b1)
      $display("FAIL misaligned_pulse: pc=%h mis=%b want 44/1", pc, misaligned_target); else passes++;
    redirect = 1'b0;
    step();
    checks++; if (misaligned_target !== 1'b0 || pc !== 32'h48 || ifid_pc !== 32'h44 || ifid_valid !== 1'b1)
      $display("FAIL misaligned_clear: mis=%b pc=%h ifid_pc=%h valid=%b want 0/48/44/1",
               misaligned_target, pc, ifid_pc, ifid_valid); else passes++;
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_target = 32'h3F8;
    step();
    redirect = 1'b0;
    step();
    checks++; if (pc !== 32'h3FC || imem_bus.addr !== 10'h3FC || ifid_pc !== 32'h3F8)
      $display("FAIL wrap_3fc: pc=%h addr=%h ifid_pc=%h want 3fc/3fc/3f8", pc, imem_bus.addr, ifid_pc); else passes++;
    step();
    checks++; if (pc !== 32'h400 || imem_bus.addr !== 10'h000 || ifid_instr !== 32'hA000_03FC)
      $display("FAIL wrap_400: pc=%h addr=%h instr=%h want 400/000/a00003fc", pc, imem_bus.addr, ifid_instr); else passes++;
    step();
    checks++; if (ifid_pc !== 32'h400 || ifid_instr !== 32'hA000_0000 || ifid_pc_plus4 !== 32'h404 || pc !== 32'h404)
      $display("FAIL wrap_capture: ifid_pc=%h instr=%h pc4=%h pc=%h want 400/a0000000/404/404",
               ifid_pc, ifid_instr, ifid_pc_plus4, pc); else passes++;
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b1;
    step();
    reset = 1'b1;
    step();
    checks++; if (pc !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13 || ifid_pc !== 32'h0 ||
                  ifid_pc_plus4 !== 32'h0 || misaligned_target !== 1'b0)
      $display("FAIL reset_mid_stall: pc=%h valid=%b instr=%h ifid_pc=%h pc4=%h mis=%b want all reset",
               pc, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4, misaligned_target); else passes++;
    stall = 1'b0; redirect = 1'b1; redirect_target = 32'h82;
    step();
    checks++; if (pc !== 32'h0 || misaligned_target !== 1'b0 || ifid_valid !== 1'b0)
      $display("FAIL reset_mid_redirect: pc=%h mis=%b valid=%b want 0/0/0", pc, misaligned_target, ifid_valid); else passes++;
    reset = 1'b0; redirect = 1'b0;
    step();
    checks++; if (ifid_pc !== 32'h0 || ifid_valid !== 1'b1 || ifid_instr !== 32'hA000_0000 || pc !== 32'h4)
      $display("FAIL post_reset_fetch: ifid_pc=%h valid=%b instr=%h pc=%h want 0/1/a0000000/4",
               ifid_pc, ifid_valid, ifid_instr, pc); else passes++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_misaligned();
    test_wrap();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
